// File: rtl/audio_pattern_gen.sv
// -----------------------------------------------------------------------------
// audio_pattern_gen
//   Multi-channel audio test-pattern source. A programmable divider produces a
//   sample tick; on each tick taken while idle, a frame of CH_NUM words is
//   emitted in channel order over a valid/ready handshake.
//
// Ports
//   iclk            system clock
//   irst            asynchronous active-low reset
//   ien             generator enable (low clears divider and ooverrun)
//   imode           pattern: 0 ramp, 1 constant, 2 square, 3 LFSR
//   idiv            sample period minus one, in iclk cycles
//   istep           ramp increment / constant value / square amplitude
//   iready          sink accepts the current word
//   och_data        sample word (registered)
//   och_num         channel index of och_data (registered)
//   och_data_valid  och_data/och_num valid (registered)
//   ooverrun        sticky flag: a sample tick arrived while a frame was busy
// -----------------------------------------------------------------------------
module audio_pattern_gen #(
  parameter int DATA_W = 24,
  parameter int CH_NUM = 2,
  parameter int CH_W   = 3,
  parameter int DIV_W  = 16
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              ien,
  input  logic [1:0]        imode,
  input  logic [DIV_W-1:0]  idiv,
  input  logic [DATA_W-1:0] istep,
  input  logic              iready,
  output logic [DATA_W-1:0] och_data,
  output logic [CH_W-1:0]   och_num,
  output logic              och_data_valid,
  output logic              ooverrun
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  typedef enum logic [1:0] {
    M_RAMP   = 2'd0,
    M_CONST  = 2'd1,
    M_SQUARE = 2'd2,
    M_LFSR   = 2'd3
  } mode_t;

  localparam logic [31:0]     LFSR_TAPS = 32'h8020_0003;
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(CH_NUM - 1);

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [DATA_W-1:0]  step_q, step_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               phase_q, phase_d;
  logic [31:0]        lfsr_q, lfsr_d, lfsr_nxt;
  logic [DATA_W-1:0]  data_d;
  logic [CH_W-1:0]    num_d;
  logic               valid_d;
  logic [DIV_W-1:0]   div_q;
  logic               tick;
  logic               accept;

  // Galois right-shift step.
  function automatic logic [31:0] lfsr_adv(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [DATA_W-1:0] word_f(
    input mode_t             m,
    input logic [DATA_W-1:0] s,
    input logic [CH_W-1:0]   c,
    input logic [DATA_W-1:0] acc,
    input logic              ph,
    input logic [31:0]       lfsr
  );
    logic [DATA_W-1:0] w;
    case (m)
      M_RAMP:   w = acc + DATA_W'(c);
      M_CONST:  w = s;
      M_SQUARE: w = (ph ^ c[0]) ? (-s) : s;
      default:  w = lfsr[DATA_W-1:0];
    endcase
    return w;
  endfunction

  assign tick   = ien && (div_q == idiv);
  assign accept = och_data_valid && iready;

  // Divider and overrun flag.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      div_q    <= '0;
      ooverrun <= 1'b0;
    end else if (!ien) begin
      div_q    <= '0;
      ooverrun <= 1'b0;
    end else begin
      div_q <= (div_q == idiv) ? '0 : div_q + DIV_W'(1);
      if (tick && state_q == SEND) ooverrun <= 1'b1;
    end
  end

  // State, pattern generators and registered outputs.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state_q        <= IDLE;
      mode_q         <= M_RAMP;
      step_q         <= '0;
      acc_q          <= '0;
      phase_q        <= 1'b0;
      lfsr_q         <= 32'h1;
      och_data       <= '0;
      och_num        <= '0;
      och_data_valid <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      step_q         <= step_d;
      acc_q          <= acc_d;
      phase_q        <= phase_d;
      lfsr_q         <= lfsr_d;
      och_data       <= data_d;
      och_num        <= num_d;
      och_data_valid <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    step_d   = step_q;
    acc_d    = acc_q;
    phase_d  = phase_q;
    lfsr_d   = lfsr_q;
    data_d   = och_data;
    num_d    = och_num;
    valid_d  = och_data_valid;
    lfsr_nxt = (mode_q == M_LFSR) ? lfsr_adv(lfsr_q) : lfsr_q;

    case (state_q)
      IDLE: begin
        if (tick) begin
          // Mode and step are taken straight from the inputs here because
          // they are latched on this same edge.
          mode_d  = mode_t'(imode);
          step_d  = istep;
          valid_d = 1'b1;
          num_d   = '0;
          data_d  = word_f(mode_t'(imode), istep, '0, acc_q, phase_q, lfsr_q);
          state_d = SEND;
        end
      end
      default: begin
        if (accept) begin
          // The LFSR moves on every accepted word, so the following word
          // must be built from the advanced value, not the current one.
          lfsr_d = lfsr_nxt;
          if (och_num != LAST_CH) begin
            num_d  = och_num + CH_W'(1);
            data_d = word_f(mode_q, step_q, och_num + CH_W'(1),
                            acc_q, phase_q, lfsr_nxt);
          end else begin
            valid_d = 1'b0;
            num_d   = '0;
            state_d = IDLE;
            if (mode_q == M_RAMP)   acc_d   = acc_q + step_q;
            if (mode_q == M_SQUARE) phase_d = ~phase_q;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_audio_pattern_gen.sv
module tb_audio_pattern_gen;

  localparam int DATA_W = 24;
  localparam int CH_NUM = 2;
  localparam int CH_W   = 3;
  localparam int DIV_W  = 16;

  logic              iclk = 1'b0;
  logic              irst = 1'b0;
  logic              ien = 1'b0;
  logic [1:0]        imode = '0;
  logic [DIV_W-1:0]  idiv = '0;
  logic [DATA_W-1:0] istep = '0;
  logic              iready = 1'b0;
  logic [DATA_W-1:0] och_data;
  logic [CH_W-1:0]   och_num;
  logic              och_data_valid;
  logic              ooverrun;

  audio_pattern_gen #(
    .DATA_W(DATA_W),
    .CH_NUM(CH_NUM),
    .CH_W  (CH_W),
    .DIV_W (DIV_W)
  ) dut (
    .iclk          (iclk),
    .irst          (irst),
    .ien           (ien),
    .imode         (imode),
    .idiv          (idiv),
    .istep         (istep),
    .iready        (iready),
    .och_data      (och_data),
    .och_num       (och_num),
    .och_data_valid(och_data_valid),
    .ooverrun      (ooverrun)
  );

  always #5 iclk = ~iclk;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  always @(posedge iclk) cyc_cnt++;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   num;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic [CH_W-1:0] n);
    exp_q.push_back('{data: d, num: n});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge iclk);
      #1;
    end
  endtask

  task automatic wait_valid(input string name, input int limit, output int lat);
    lat = 0;
    while (!och_data_valid && lat < limit) begin
      @(posedge iclk);
      #1;
      lat++;
    end
    if (!och_data_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: no valid within %0d cycles, expected valid", name, limit);
    end
  endtask

  task automatic wait_empty(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge iclk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d words still pending after %0d cycles, expected 0",
               name, exp_q.size(), limit);
      exp_q.delete();
    end
  endtask

  // Monitor: pops the scoreboard on every accepted word and checks that a
  // stalled word is held stable.
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;
  logic [CH_W-1:0]   prev_num   = '0;

  always @(negedge iclk) begin
    if (!irst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && och_data_valid) begin
        check("hold_data", och_data, prev_data);
        check("hold_num", och_num, prev_num);
      end
      if (och_data_valid && iready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got data 0x%0h num %0d, expected no word",
                   och_data, och_num);
        end else begin
          e = exp_q.pop_front();
          check("word_data", och_data, e.data);
          check("word_num", och_num, e.num);
        end
      end
      prev_stall = och_data_valid && !iready;
      prev_data  = och_data;
      prev_num   = och_num;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    int start0, start1, start2;

    // Reset values while inputs move.
    for (int i = 0; i < 4; i++) begin
      ien    = i[0];
      imode  = i[1:0];
      idiv   = DIV_W'(i);
      istep  = DATA_W'(i * 777 + 1);
      iready = ~i[0];
      #7;
      check("rst_data", och_data, 0);
      check("rst_num", och_num, 0);
      check("rst_valid", och_data_valid, 0);
      check("rst_overrun", ooverrun, 0);
    end
    ien = 1'b0; imode = '0; idiv = '0; istep = '0; iready = 1'b1;
    @(posedge iclk);
    #1;
    irst = 1'b1;
    seen = 0;
    repeat (100) begin
      @(negedge iclk);
      if (och_data_valid) seen++;
    end
    check("idle_no_valid", seen, 0);
    cyc(1);

    // Ramp with a 5-cycle stall on ch1 of the first frame.
    idiv = 9; istep = 16; imode = 0; iready = 1'b1;
    push(24'd0, 3'd0); push(24'd1, 3'd1);
    push(24'd16, 3'd0); push(24'd17, 3'd1);
    push(24'd32, 3'd0); push(24'd33, 3'd1);
    ien = 1'b1;
    wait_valid("ramp_first", 40, lat);
    check("ramp_latency", lat + 1, 11);
    start0 = cyc_cnt;
    cyc(1);
    iready = 1'b0;
    check("stall_data", och_data, 1);
    check("stall_num", och_num, 1);
    cyc(5);
    iready = 1'b1;
    cyc(1);
    wait_valid("ramp_frame1", 20, lat);
    start1 = cyc_cnt;
    check("ramp_period_0_1", start1 - start0, 10);
    cyc(2);
    wait_valid("ramp_frame2", 20, lat);
    start2 = cyc_cnt;
    check("ramp_period_1_2", start2 - start1, 10);
    wait_empty("ramp_drain", 20);
    ien = 1'b0;
    check("ramp_no_overrun", ooverrun, 0);
    cyc(2);

    // Overrun with tick every cycle and no sink.
    idiv = 0; imode = 1; istep = 5; iready = 1'b0;
    ien = 1'b1;
    wait_valid("ovr_first", 10, lat);
    check("ovr_at_first_valid", ooverrun, 0);
    cyc(1);
    check("ovr_set", ooverrun, 1);
    cyc(3);
    check("ovr_sticky", ooverrun, 1);
    ien = 1'b0;
    cyc(1);
    check("ovr_clear", ooverrun, 0);
    check("ien_off_frame_held", och_data_valid, 1);
    push(24'd5, 3'd0); push(24'd5, 3'd1);
    iready = 1'b1;
    wait_empty("ovr_drain", 10);
    seen = 0;
    repeat (20) begin
      @(negedge iclk);
      if (och_data_valid) seen++;
    end
    check("ien_off_no_new_frame", seen, 0);
    cyc(1);

    // Square, then a mid-frame switch to constant.
    idiv = 9; imode = 2; istep = 24'h000100; iready = 1'b1;
    push(24'h000100, 3'd0); push(24'hFFFF00, 3'd1);
    push(24'hFFFF00, 3'd0); push(24'h000100, 3'd1);
    ien = 1'b1;
    wait_empty("sq_drain", 60);
    iready = 1'b0;
    wait_valid("sq_frame2", 20, lat);
    check("sq_frame2_ch0", och_data, 24'h000100);
    imode = 1; istep = 24'h123456;
    push(24'h000100, 3'd0); push(24'hFFFF00, 3'd1);
    push(24'h123456, 3'd0); push(24'h123456, 3'd1);
    cyc(2);
    iready = 1'b1;
    wait_empty("const_drain", 60);
    check("sq_no_overrun", ooverrun, 0);
    ien = 1'b0;
    cyc(2);

    // LFSR, then an asynchronous reset mid-frame.
    irst = 1'b0;
    cyc(2);
    irst = 1'b1;
    imode = 3; idiv = 3; iready = 1'b1;
    push(24'h000001, 3'd0); push(24'h200003, 3'd1);
    push(24'h300002, 3'd0); push(24'h180001, 3'd1);
    ien = 1'b1;
    wait_empty("lfsr_drain", 40);
    iready = 1'b0;
    wait_valid("lfsr_frame2", 20, lat);
    check("lfsr_stalled_word", och_data, 24'h2C0003);
    #2;
    irst = 1'b0;
    #1;
    check("async_rst_valid", och_data_valid, 0);
    check("async_rst_data", och_data, 0);
    check("async_rst_overrun", ooverrun, 0);
    @(posedge iclk);
    #1;
    irst = 1'b1;
    push(24'h000001, 3'd0); push(24'h200003, 3'd1);
    iready = 1'b1;
    wait_empty("lfsr_restart", 20);
    ien = 1'b0;
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
